// File: rtl/aes_enc_core.sv
// Iterative AES-128/192/256 encryptor; one round per cycle from a register-based round-key store (optional AES_ZEROIZE_EN).
// Latency: key schedule NW-NK cycles after key accept; ciphertext valid NR cycles after block accept.
// Backpressure: ciphertext held in DONE until out_ready_i; key and block inputs are accepted only in IDLE.
module aes_enc_core #(
    parameter int KEY_WIDTH  = 128,
    parameter int TEXT_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [KEY_WIDTH-1:0]  key_i,
    input  logic                  key_valid_i,
    output logic                  key_ready_o,
    output logic                  key_ok_o,
    input  logic [TEXT_WIDTH-1:0] plaintext_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [TEXT_WIDTH-1:0] ciphertext_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [3:0]            round_o
`ifdef AES_ZEROIZE_EN
    ,
    input  logic                  zeroize_i
`endif
);

    localparam int NK = KEY_WIDTH / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_KEXP  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    generate
        if (!(KEY_WIDTH == 128 || KEY_WIDTH == 192 || KEY_WIDTH == 256)) begin : g_bad_key_width
            $error("aes_enc_core: KEY_WIDTH must be 128, 192 or 256");
        end
        if (TEXT_WIDTH != 128) begin : g_bad_text_width
            $error("aes_enc_core: TEXT_WIDTH must be 128");
        end
    endgenerate

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Bytes are column-major: byte 4*c+r is row r of column c, byte 0 in the MSBs.
    function automatic logic [0:15][7:0] sub_shift(input logic [0:15][7:0] s);
        logic [0:15][7:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4*c+r] = SBOX[s[4*((c+r)%4)+r]];
            end
        end
        return o;
    endfunction

    function automatic logic [0:15][7:0] mix_columns(input logic [0:15][7:0] s);
        logic [0:15][7:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4*c];
            a1 = s[4*c+1];
            a2 = s[4*c+2];
            a3 = s[4*c+3];
            o[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic [5:0]       i_q, i_d;
    logic [7:0]       rcon_q, rcon_d;
    logic             key_ok_q, key_ok_d;
    logic [0:15][7:0] data_q, data_d;
    logic [0:15][7:0] ct_q, ct_d;
    logic [31:0]      rk_q [NW];

    logic             zero_clr;
    logic             key_fire, blk_fire, last_round;
    logic [5:0]       i_mod;
    logic [31:0]      w_prev, w_back, kx_sub, kx_temp, kx_word;
    logic [0:15][7:0] sr, mc, rk_cur, rk0, round_out;

`ifdef AES_ZEROIZE_EN
    assign zero_clr = zeroize_i && (state_q == S_IDLE || state_q == S_DONE);
`else
    assign zero_clr = 1'b0;
`endif

    // A simultaneous key offer takes priority, so the block side is refused that cycle.
    assign key_ready_o  = (state_q == S_IDLE) && !zero_clr;
    assign in_ready_o   = (state_q == S_IDLE) && key_ok_q && !key_valid_i && !zero_clr;
    assign key_fire     = key_valid_i && key_ready_o;
    assign blk_fire     = in_valid_i && in_ready_o;
    assign out_valid_o  = (state_q == S_DONE);
    assign key_ok_o     = key_ok_q;
    assign ciphertext_o = ct_q;
    assign round_o      = round_q;

    assign w_prev  = rk_q[i_q - 6'd1];
    assign w_back  = rk_q[i_q - 6'(NK)];
    assign i_mod   = i_q % 6'(NK);
    assign kx_sub  = sub_word((i_mod == 6'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev);
    assign kx_word = w_back ^ kx_temp;

    always_comb begin
        kx_temp = w_prev;
        if (i_mod == 6'd0) begin
            kx_temp = kx_sub ^ {rcon_q, 24'h0};
        end else if (NK == 8 && i_mod == 6'd4) begin
            kx_temp = kx_sub;
        end
    end

    assign rk0        = {rk_q[0], rk_q[1], rk_q[2], rk_q[3]};
    assign rk_cur     = {rk_q[{round_q, 2'd0}], rk_q[{round_q, 2'd1}],
                         rk_q[{round_q, 2'd2}], rk_q[{round_q, 2'd3}]};
    assign last_round = (round_q == 4'(NR));
    assign sr         = sub_shift(data_q);
    assign mc         = mix_columns(sr);
    assign round_out  = (last_round ? sr : mc) ^ rk_cur;

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        i_d      = i_q;
        rcon_d   = rcon_q;
        key_ok_d = key_ok_q;
        data_d   = data_q;
        ct_d     = ct_q;
        case (state_q)
            S_IDLE: begin
                if (key_fire) begin
                    state_d  = S_KEXP;
                    key_ok_d = 1'b0;
                    i_d      = 6'(NK);
                    rcon_d   = 8'h01;
                end else if (blk_fire) begin
                    state_d = S_ROUND;
                    data_d  = plaintext_i ^ rk0;
                    round_d = 4'd1;
                end
            end
            S_KEXP: begin
                i_d = i_q + 6'd1;
                if (i_mod == 6'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == 6'(NW - 1)) begin
                    key_ok_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_ROUND: begin
                if (last_round) begin
                    ct_d    = round_out;
                    round_d = 4'd0;
                    state_d = S_DONE;
                end else begin
                    data_d  = round_out;
                    round_d = round_q + 4'd1;
                end
            end
            default: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
        endcase
        if (zero_clr) begin
            state_d  = S_IDLE;
            key_ok_d = 1'b0;
            data_d   = '0;
            ct_d     = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            round_q  <= '0;
            i_q      <= '0;
            rcon_q   <= '0;
            key_ok_q <= 1'b0;
            data_q   <= '0;
            ct_q     <= '0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            i_q      <= i_d;
            rcon_q   <= rcon_d;
            key_ok_q <= key_ok_d;
            data_q   <= data_d;
            ct_q     <= ct_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NW; k++) rk_q[k] <= '0;
        end else if (zero_clr) begin
            for (int k = 0; k < NW; k++) rk_q[k] <= '0;
        end else if (key_fire) begin
            for (int k = 0; k < NK; k++) rk_q[k] <= key_i[KEY_WIDTH-1-32*k -: 32];
        end else if (state_q == S_KEXP) begin
            rk_q[i_q] <= kx_word;
        end
    end

endmodule

// File: tb/tb_aes_enc_core.sv
// Bench for aes_enc_core at all three key widths against a byte-level AES model with a computed S-box.
module tb_aes_enc_core;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                 rst_n;
    logic [2:0][255:0]    key_dat;
    logic [2:0]           key_vld, in_vld, out_rdy;
    logic [2:0][127:0]    pt;
    wire  [2:0]           key_rdy, key_ok, in_rdy, out_vld;
    wire  [2:0][127:0]    ct;
    wire  [2:0][3:0]      rnd;
`ifdef AES_ZEROIZE_EN
    logic [2:0]           zer;
`endif

    int          checks = 0;
    int          errors = 0;
    int          issued [3];
    int          retired [3];
    logic [127:0] exp_ct [3];
    logic [255:0] cur_key [3];
    logic [7:0]  sb [256];

    localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY_A = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_B = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT_B  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C  = 128'h8ea2b7ca516745bfeafc49904b496089;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_enc_core #(.KEY_WIDTH(128 + 64*g), .TEXT_WIDTH(128)) u_dut (
            .clk_i        (clk_i),
            .rst_ni       (rst_n),
            .key_i        (key_dat[g][128+64*g-1:0]),
            .key_valid_i  (key_vld[g]),
            .key_ready_o  (key_rdy[g]),
            .key_ok_o     (key_ok[g]),
            .plaintext_i  (pt[g]),
            .in_valid_i   (in_vld[g]),
            .in_ready_o   (in_rdy[g]),
            .ciphertext_o (ct[g]),
            .out_valid_o  (out_vld[g]),
            .out_ready_i  (out_rdy[g]),
            .round_o      (rnd[g])
`ifdef AES_ZEROIZE_EN
            ,
            .zeroize_i    (zer[g])
`endif
        );
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_model(input logic [255:0] key, input int nk, input logic [127:0] p);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] r;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int k = 0; k < nk; k++) w[k] = key[32*nk-1-32*k -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = p[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int n = 0; n < 16; n++) s[n] = sb[s[n]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    if (rd != nr)
                        s[4*c+q] = gmul(t[4*c+q], 8'h02) ^ gmul(t[4*c+(q+1)%4], 8'h03)
                                   ^ t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4];
                    else
                        s[4*c+q] = t[4*c+q];
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rd + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) r[127-8*n -: 8] = s[n];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard: every cycle a ciphertext is offered it must match the oldest outstanding model result.
    always @(negedge clk_i) begin
        if (rst_n === 1'b1) begin
            for (int g = 0; g < 3; g++) begin
                if (out_vld[g]) begin
                    check("sb_pending", (issued[g] != retired[g]) ? 1 : 0, 1);
                    check("sb_ct", ct[g], exp_ct[g]);
                    check("sb_done_in_ready", in_rdy[g], 0);
                    check("sb_done_key_ready", key_rdy[g], 0);
                    if (out_rdy[g]) retired[g]++;
                end
            end
        end
    end

    task automatic key_load(input int g, input logic [255:0] key, input bit with_blk);
        int n;
        cur_key[g] = key;
        key_dat[g] = key;
        key_vld[g] = 1'b1;
        if (with_blk) begin
            pt[g] = rand128();
            in_vld[g] = 1'b1;
        end
        #1;
        n = 0;
        while (!key_rdy[g] && n < 100) begin @(posedge clk_i); #1; n++; end
        check("key_ready", key_rdy[g], 1);
        if (with_blk) check("key_wins_in_ready", in_rdy[g], 0);
        @(posedge clk_i); #1;
        key_vld[g] = 1'b0;
        in_vld[g] = 1'b0;
        check("kexp_key_ok_low", key_ok[g], 0);
        check("kexp_key_ready_low", key_rdy[g], 0);
        n = 0;
        while (!key_ok[g] && n < 200) begin @(posedge clk_i); #1; n++; end
        check("key_load_latency", n, 4*(4+2*g+7) - (4+2*g));
    endtask

    task automatic enc_block(input int g, input logic [127:0] p, input int stall,
                             input bit has_lit, input logic [127:0] lit);
        int n;
        logic [127:0] e;
        e = aes_model(cur_key[g], 4 + 2*g, p);
        if (has_lit) check("model_vector", e, lit);
        pt[g] = p;
        in_vld[g] = 1'b1;
        out_rdy[g] = (stall == 0);
        #1;
        n = 0;
        while (!in_rdy[g] && n < 200) begin @(posedge clk_i); #1; n++; end
        check("in_ready", in_rdy[g], 1);
        exp_ct[g] = e;
        issued[g]++;
        @(posedge clk_i); #1;
        in_vld[g] = 1'b0;
        n = 0;
        while (!out_vld[g] && n < 100) begin @(posedge clk_i); #1; n++; end
        check("enc_latency", n, 10 + 2*g);
        if (has_lit) check("ct_vector", ct[g], lit);
        repeat (stall) begin
            @(posedge clk_i); #1;
            check("stall_valid_hold", out_vld[g], 1);
            check("stall_ct_hold", ct[g], e);
            check("stall_in_ready", in_rdy[g], 0);
        end
        out_rdy[g] = 1'b1;
        @(posedge clk_i); #1;
        check("out_valid_drop", out_vld[g], 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        logic [7:0] inv;
        rst_n   = 1'b0;
        key_vld = '0;
        in_vld  = '0;
        out_rdy = '1;
        key_dat = '0;
        pt      = '0;
`ifdef AES_ZEROIZE_EN
        zer     = '0;
`endif
        for (int g = 0; g < 3; g++) begin
            issued[g] = 0;
            retired[g] = 0;
            exp_ct[g] = '0;
            cur_key[g] = '0;
        end

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        check("model_sbox_00", sb[0], 8'h63);
        check("model_sbox_53", sb[8'h53], 8'hed);

        #1;
        for (int g = 0; g < 3; g++) begin
            check("reset_key_ready", key_rdy[g], 1);
            check("reset_key_ok", key_ok[g], 0);
            check("reset_in_ready", in_rdy[g], 0);
            check("reset_out_valid", out_vld[g], 0);
            check("reset_ct", ct[g], 0);
            check("reset_round", rnd[g], 0);
        end
        repeat (2) @(posedge clk_i);
        #3 rst_n = 1'b1;
        @(posedge clk_i); #1;

        key_load(0, KEY_A, 0);
        enc_block(0, PT_A, 0, 1, CT_A);
        key_load(1, KEY_B, 0);
        enc_block(1, PT_C, 0, 1, CT_B);
        key_load(2, KEY_C, 0);
        enc_block(2, PT_C, 0, 1, CT_C);
        for (int g = 1; g < 3; g++) enc_block(g, rand128(), 0, 0, '0);

        key_load(0, {128'h0, rand128()}, 0);
        enc_block(0, rand128(), 0, 0, '0);
        enc_block(0, rand128(), 5, 0, '0);
        enc_block(0, rand128(), 0, 0, '0);

        key_load(0, {128'h0, rand128()}, 1);
        enc_block(0, rand128(), 0, 0, '0);

        key_load(0, KEY_A, 0);
        pt[0] = PT_A;
        in_vld[0] = 1'b1;
        #1;
        check("rst_test_in_ready", in_rdy[0], 1);
        @(posedge clk_i); #1;
        in_vld[0] = 1'b0;
        n = 0;
        while (rnd[0] != 4'd5 && n < 50) begin @(posedge clk_i); #1; n++; end
        check("rst_round5", rnd[0], 5);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            check("midrst_key_ok", key_ok[g], 0);
            check("midrst_key_ready", key_rdy[g], 1);
            check("midrst_in_ready", in_rdy[g], 0);
            check("midrst_out_valid", out_vld[g], 0);
            check("midrst_ct", ct[g], 0);
            check("midrst_round", rnd[g], 0);
            issued[g] = retired[g];
        end
        @(posedge clk_i);
        #3 rst_n = 1'b1;
        @(posedge clk_i); #1;
        key_load(0, KEY_A, 0);
        enc_block(0, PT_A, 0, 1, CT_A);

`ifdef AES_ZEROIZE_EN
        pt[0] = rand128();
        exp_ct[0] = aes_model(cur_key[0], 4, pt[0]);
        issued[0]++;
        in_vld[0] = 1'b1;
        out_rdy[0] = 1'b0;
        #1;
        check("zero_in_ready", in_rdy[0], 1);
        @(posedge clk_i); #1;
        in_vld[0] = 1'b0;
        n = 0;
        while (!out_vld[0] && n < 100) begin @(posedge clk_i); #1; n++; end
        check("zero_done_reached", out_vld[0], 1);
        zer[0] = 1'b1;
        @(posedge clk_i); #1;
        zer[0] = 1'b0;
        check("zero_out_valid", out_vld[0], 0);
        check("zero_key_ok", key_ok[0], 0);
        check("zero_ct", ct[0], 0);
        issued[0] = retired[0];
        out_rdy[0] = 1'b1;
        in_vld[0] = 1'b1;
        repeat (3) begin
            #1;
            check("zero_in_ready_held", in_rdy[0], 0);
            @(posedge clk_i); #1;
        end
        in_vld[0] = 1'b0;
        key_load(0, {128'h0, rand128()}, 0);
        enc_block(0, rand128(), 0, 0, '0);
`endif

        repeat (3) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
